// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl -- writeback sequencer for the rv32 core.
//
// Owns the single register-file write port. Two sources share it:
//   * ALU / PC+4 results: written the cycle after issue, back-to-back capable.
//   * Loads: a request is issued to data memory, the front of the pipeline is
//     stalled until the memory acks, then the (optionally byte-extracted) data
//     is committed in a dedicated COMMIT cycle.
// Writes to x0 are suppressed on both paths; a load to x0 still performs the
// complete memory handshake.
//
// Optional feature macro: WB_TIMEOUT_EN
//   defined   -> an 8-bit wait counter aborts a load after TIMEOUT cycles without
//                an ack, pulsing load_fault and returning to IDLE without a write.
//   undefined -> no counter, WAIT_MEM waits indefinitely, load_fault tied to 0.
//
// Ports:
//   clk, nrst              core clock, asynchronous active-low reset
//   issue_valid, rd        instruction presented for writeback, destination reg
//   mem_to_reg, load_byte  load / byte-load (zero-extend bits [7:0]) qualifiers
//   read_pc_4              write PC+4 instead (jal/jalr), overrides mem_to_reg
//   alu_value, pc_4_value  ALU result (also load address), PC+4
//   mem_rd_req, mem_addr   load request and latched load address (registered)
//   mem_ack, mem_rdata     memory completion handshake and read data
//   reg_we/waddr/wdata     register-file write port (registered, 1-cycle pulse)
//   stall                  upstream must hold its instruction (state != IDLE)
//   load_fault             one-cycle pulse on load timeout (registered)
// -----------------------------------------------------------------------------
module wb_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] rd,
    input  logic              mem_to_reg,
    input  logic              load_byte,
    input  logic              read_pc_4,
    input  logic [DATA_W-1:0] alu_value,
    input  logic [DATA_W-1:0] pc_4_value,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              stall,
    output logic              load_fault
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } state_t;

    // The 8-bit limit compare below only works for limits that fit the counter.
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("wb_ctrl: TIMEOUT must lie in 2..255");
    end

    // Returned load data: byte loads zero-extend the low byte, word loads pass through.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic              byte_sel,
        input logic [DATA_W-1:0] raw
    );
        logic [DATA_W-1:0] val;
        if (byte_sel) begin
            val = {{(DATA_W-8){1'b0}}, raw[7:0]};
        end else begin
            val = raw;
        end
        return val;
    endfunction

    state_t              state_r,       state_s;
    logic                mem_rd_req_r,  req_s;
    logic [DATA_W-1:0]   mem_addr_r,    addr_s;
    logic                reg_we_r,      we_s;
    logic [REG_AW-1:0]   reg_waddr_r,   waddr_s;
    logic [DATA_W-1:0]   reg_wdata_r,   wdata_s;
    logic [REG_AW-1:0]   ld_rd_r,       ld_rd_s;
    logic                ld_byte_r,     ld_byte_s;
    logic                rd_nonzero_s;
    logic                ld_rd_nonzero_s;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0]          tmo_cnt_r,     tmo_cnt_s;
    logic                load_fault_r,  fault_s;
`endif

    assign rd_nonzero_s    = (rd != {REG_AW{1'b0}});
    assign ld_rd_nonzero_s = (ld_rd_r != {REG_AW{1'b0}});

    // Next-state and next-output decode; registered values hold unless a branch updates them.
    always_comb begin
        state_s   = state_r;
        req_s     = mem_rd_req_r;
        addr_s    = mem_addr_r;
        we_s      = 1'b0;
        waddr_s   = reg_waddr_r;
        wdata_s   = reg_wdata_r;
        ld_rd_s   = ld_rd_r;
        ld_byte_s = ld_byte_r;
`ifdef WB_TIMEOUT_EN
        tmo_cnt_s = tmo_cnt_r;
        fault_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (issue_valid) begin
                    if (read_pc_4 || !mem_to_reg) begin
                        // Single-cycle result; x0 is never written.
                        if (rd_nonzero_s) begin
                            we_s    = 1'b1;
                            waddr_s = rd;
                            wdata_s = read_pc_4 ? pc_4_value : alu_value;
                        end else begin
                            we_s    = 1'b0;
                        end
                    end else begin
                        state_s   = ST_WAIT_MEM;
                        req_s     = 1'b1;
                        addr_s    = alu_value;
                        ld_rd_s   = rd;
                        ld_byte_s = load_byte;
`ifdef WB_TIMEOUT_EN
                        tmo_cnt_s = 8'd0;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ack) begin
                    // Ack wins over a simultaneous timeout limit.
                    state_s = ST_COMMIT;
                    req_s   = 1'b0;
                    if (ld_rd_nonzero_s) begin
                        we_s    = 1'b1;
                        waddr_s = ld_rd_r;
                        wdata_s = load_extract(ld_byte_r, mem_rdata);
                    end else begin
                        we_s    = 1'b0;
                    end
`ifdef WB_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LIMIT) begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                    fault_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
`else
                end else begin
                    state_s = ST_WAIT_MEM;
                end
`endif
            end
            ST_COMMIT: begin
                // The write pulse was registered on the ack edge; just release the stall.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, including data/address.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= ST_IDLE;
            mem_rd_req_r <= 1'b0;
            mem_addr_r   <= {DATA_W{1'b0}};
            reg_we_r     <= 1'b0;
            reg_waddr_r  <= {REG_AW{1'b0}};
            reg_wdata_r  <= {DATA_W{1'b0}};
            ld_rd_r      <= {REG_AW{1'b0}};
            ld_byte_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            mem_rd_req_r <= req_s;
            mem_addr_r   <= addr_s;
            reg_we_r     <= we_s;
            reg_waddr_r  <= waddr_s;
            reg_wdata_r  <= wdata_s;
            ld_rd_r      <= ld_rd_s;
            ld_byte_r    <= ld_byte_s;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Load-wait counter and registered timeout pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt_r    <= 8'd0;
            load_fault_r <= 1'b0;
        end else begin
            tmo_cnt_r    <= tmo_cnt_s;
            load_fault_r <= fault_s;
        end
    end

    assign load_fault = load_fault_r;
`else
    assign load_fault = 1'b0;
`endif

    assign mem_rd_req = mem_rd_req_r;
    assign mem_addr   = mem_addr_r;
    assign reg_we     = reg_we_r;
    assign reg_waddr  = reg_waddr_r;
    assign reg_wdata  = reg_wdata_r;
    assign stall      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl -- self-checking bench for wb_ctrl.
// A transaction-level reference model (pending load record + due write) predicts
// every output each cycle; directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_wb_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;
`ifdef WB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          issue_valid;
    logic [AW-1:0] rd;
    logic          mem_to_reg;
    logic          load_byte;
    logic          read_pc_4;
    logic [DW-1:0] alu_value;
    logic [DW-1:0] pc_4_value;
    logic          mem_rd_req;
    logic [DW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          reg_we;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic          stall;
    logic          load_fault;

    wb_ctrl #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .issue_valid(issue_valid), .rd(rd),
        .mem_to_reg(mem_to_reg), .load_byte(load_byte), .read_pc_4(read_pc_4),
        .alu_value(alu_value), .pc_4_value(pc_4_value), .mem_rd_req(mem_rd_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .stall(stall), .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fault_pulses = 0;

    // Reference model: expected outputs plus the outstanding-load record.
    logic          m_req, m_we, m_fault, m_commit, m_byte;
    logic [DW-1:0] m_addr, m_wdata;
    logic [AW-1:0] m_waddr, m_rd;
    int            m_wait;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_we = 1'b0; m_fault = 1'b0; m_commit = 1'b0; m_byte = 1'b0;
        m_addr = '0; m_wdata = '0; m_waddr = '0; m_rd = '0; m_wait = 0;
    endtask

    task automatic check_all();
        check_val("mem_rd_req", 32'(mem_rd_req), 32'(m_req));
        check_val("mem_addr",   mem_addr,        m_addr);
        check_val("reg_we",     32'(reg_we),     32'(m_we));
        check_val("reg_waddr",  32'(reg_waddr),  32'(m_waddr));
        check_val("reg_wdata",  reg_wdata,       m_wdata);
        check_val("load_fault", 32'(load_fault), 32'(m_fault));
        check_val("stall",      32'(stall),      32'(m_req || m_commit));
    endtask

    task automatic drive(input logic iv, input logic [AW-1:0] r, input logic m2r,
                         input logic lb, input logic pc4, input logic [DW-1:0] alu,
                         input logic [DW-1:0] pcv, input logic ack, input logic [DW-1:0] rdata);
        issue_valid = iv; rd = r; mem_to_reg = m2r; load_byte = lb; read_pc_4 = pc4;
        alu_value = alu; pc_4_value = pcv; mem_ack = ack; mem_rdata = rdata;
    endtask

    task automatic drive_random();
        logic [AW-1:0] r;
        r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        drive(($urandom_range(0, 9) < 6), r, ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 2), $urandom, $urandom, ($urandom_range(0, 9) < 3), $urandom);
    endtask

    // Advance one clock: predict from current inputs, then compare at the falling edge.
    task automatic step();
        logic          n_req, n_we, n_fault, n_commit, n_byte;
        logic [DW-1:0] n_addr, n_wdata;
        logic [AW-1:0] n_waddr, n_rd;
        int            n_wait;
        n_req = m_req; n_we = 1'b0; n_fault = 1'b0; n_commit = m_commit; n_byte = m_byte;
        n_addr = m_addr; n_wdata = m_wdata; n_waddr = m_waddr; n_rd = m_rd; n_wait = m_wait;
        if (!(m_req || m_commit)) begin
            if (issue_valid) begin
                if (read_pc_4 || !mem_to_reg) begin
                    if (rd != 0) begin
                        n_we = 1'b1; n_waddr = rd;
                        n_wdata = read_pc_4 ? pc_4_value : alu_value;
                    end
                end else begin
                    n_req = 1'b1; n_addr = alu_value; n_rd = rd; n_byte = load_byte; n_wait = 0;
                end
            end
        end else if (m_req) begin
            if (mem_ack) begin
                n_req = 1'b0; n_commit = 1'b1;
                if (m_rd != 0) begin
                    n_we = 1'b1; n_waddr = m_rd;
                    n_wdata = m_byte ? (mem_rdata & 32'h0000_00FF) : mem_rdata;
                end
            end else if (TMO_ON && (m_wait == TO - 1)) begin
                n_req = 1'b0; n_fault = 1'b1;
            end else begin
                n_wait = m_wait + 1;
            end
        end else begin
            n_commit = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        m_req = n_req; m_we = n_we; m_fault = n_fault; m_commit = n_commit; m_byte = n_byte;
        m_addr = n_addr; m_wdata = n_wdata; m_waddr = n_waddr; m_rd = n_rd; m_wait = n_wait;
        if (load_fault === 1'b1) fault_pulses++;
        check_all();
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        // Reset with random inputs: everything must read zero.
        nrst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(negedge clk);
            check_all();
        end
        idle_in();
        nrst = 1'b1;
        step();

        // ALU path and back-to-back writes.
        drive(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0ABC, 1'b0, 32'd0);
        step();
        check_val("alu_we", 32'(reg_we), 32'd1);
        check_val("alu_wdata", reg_wdata, 32'h0000_1234);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i + 10), 1'b0, 1'b0, 1'b0, 32'(i * 32'h111), 32'd0, 1'b0, 32'd0);
            step();
            check_val("b2b_we", 32'(reg_we), 32'd1);
        end

        // PC+4 overrides mem_to_reg.
        drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h5555_0000, 32'h0000_0104, 1'b0, 32'd0);
        step();
        check_val("pc4_wdata", reg_wdata, 32'h0000_0104);
        idle_in();
        step();
        check_val("pc4_noreq", 32'(mem_rd_req), 32'd0);

        // Byte load with four wait cycles; further issues during the stall are ignored.
        drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 1'b0, 32'd0);
        step();
        check_val("ld_addr", mem_addr, 32'h8000_0010);
        check_val("ld_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, $urandom);
            step();
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        check_val("byte_wdata", reg_wdata, 32'h0000_00EF);
        check_val("byte_waddr", 32'(reg_waddr), 32'd7);
        idle_in();
        step();
        check_val("post_commit_stall", 32'(stall), 32'd0);

        // x0 destinations: ALU write and word load both leave reg_we low.
        drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'd0, 1'b0, 32'd0);
        step();
        drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'd0, 1'b0, 32'd0);
        step();
        idle_in();
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h1234_5678);
        step();
        check_val("x0_load_we", 32'(reg_we), 32'd0);
        idle_in();
        step();

        // Never acked: faults once with the timeout built in, otherwise keeps waiting.
        fault_pulses = 0;
        drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'd0, 1'b0, 32'd0);
        step();
        idle_in();
        for (int i = 0; i < TO + 2; i++) step();
        check_val("tmo_pulses", 32'(fault_pulses), TMO_ON ? 32'd1 : 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0077);
        step();
        idle_in();
        step();
        step();

        // Ack on the limit cycle commits without a fault.
        drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'd0, 1'b0, 32'd0);
        step();
        idle_in();
        for (int i = 0; i < TO - 1; i++) step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0BAD_F00D);
        step();
        check_val("limit_we", 32'(reg_we), 32'd1);
        check_val("limit_fault", 32'(load_fault), 32'd0);
        idle_in();
        step();

        // Reset in the middle of a load drops the request immediately.
        drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000_0C00, 32'd0, 1'b0, 32'd0);
        step();
        idle_in();
        step();
        nrst = 1'b0;
        #1;
        model_reset();
        check_val("rst_req_drop", 32'(mem_rd_req), 32'd0);
        check_all();
        @(negedge clk);
        nrst = 1'b1;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
